// File: rtl/pipe_credit_fifo.sv
// rtl/pipe_credit_fifo.sv - credit-gated receive FIFO behind a fixed-latency non-stallable pipeline (optional PIPE_CREDIT_FIFO_ERR_CHECK_EN adds sticky err)
module pipe_credit_fifo #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 8,
    parameter int LATENCY = 4
) (
    input  logic                     CLK,
    input  logic                     ASYNCRESETN,
    input  logic                     launch,
    output logic                     credit_ok,
    input  logic [WIDTH-1:0]         I,
    input  logic                     I_valid,
    output logic [WIDTH-1:0]         O,
    output logic                     O_valid,
    input  logic                     O_ready,
`ifdef PIPE_CREDIT_FIFO_ERR_CHECK_EN
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
`else
    output logic [$clog2(DEPTH):0]   count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(LATENCY + 1);
    localparam int SW = CW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [FW-1:0]    inflight;
    logic [SW-1:0]    reserved;
    logic             full;
    logic             pop;
    logic             push;
    logic             inc_inflight;
    logic             dec_inflight;

    // Reserved slots = stored words plus words still travelling through the pipeline.
    always_comb begin
        reserved     = {1'b0, count} + SW'(inflight);
        credit_ok    = reserved < SW'(DEPTH);
        full         = count == CW'(DEPTH);
        O_valid      = count != '0;
        O            = mem[rd_ptr];
        pop          = O_valid && O_ready;
        // A pop on a full FIFO frees the slot the arriving word needs.
        push         = I_valid && (!full || pop);
        inc_inflight = launch && credit_ok;
        // Guard against an I_valid with nothing launched (forced input) wrapping the counter.
        dec_inflight = I_valid && (inflight != '0);
    end

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= I;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Words launched but not yet arrived; a launch without credit is not counted.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            inflight <= '0;
        end else begin
            case ({inc_inflight, dec_inflight})
                2'b10:   inflight <= inflight + FW'(1);
                2'b01:   inflight <= inflight - FW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

`ifdef PIPE_CREDIT_FIFO_ERR_CHECK_EN
    // Sticky protocol-violation flag: launch without credit, or an arriving word dropped on full.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            err <= 1'b0;
        end else if ((launch && !credit_ok) || (I_valid && !push)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_credit_fifo.sv
// tb/tb_pipe_credit_fifo.sv - scoreboard bench for pipe_credit_fifo with a 4-stage pipeline model
module tb_pipe_credit_fifo;

    localparam int W = 4;
    localparam int D = 8;
    localparam int L = 4;

    logic         CLK = 1'b0;
    logic         ASYNCRESETN = 1'b0;
    logic         launch = 1'b0;
    logic [W-1:0] launch_data = '0;
    logic         O_ready = 1'b0;
    logic         force_valid = 1'b0;
    logic [W-1:0] force_data = '0;
    logic         credit_ok;
    logic [W-1:0] I;
    logic         I_valid;
    logic [W-1:0] O;
    logic         O_valid;
    logic [3:0]   count;
`ifdef PIPE_CREDIT_FIFO_ERR_CHECK_EN
    logic         err;
`endif

    logic [L-1:0]        pipe_v;
    logic [L-1:0][W-1:0] pipe_d;
    logic [W-1:0]        exp_q [$];
    logic [W-1:0]        exp_word;
    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    pipe_credit_fifo #(.WIDTH(W), .DEPTH(D), .LATENCY(L)) dut (
        .CLK(CLK),
        .ASYNCRESETN(ASYNCRESETN),
        .launch(launch),
        .credit_ok(credit_ok),
        .I(I),
        .I_valid(I_valid),
        .O(O),
        .O_valid(O_valid),
        .O_ready(O_ready),
`ifdef PIPE_CREDIT_FIFO_ERR_CHECK_EN
        .count(count),
        .err(err)
`else
        .count(count)
`endif
    );

    // Well-behaved upstream pipeline: only credited launches enter it.
    always @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            pipe_v <= '0;
            pipe_d <= '0;
        end else begin
            pipe_v <= {pipe_v[L-2:0], launch && credit_ok};
            pipe_d <= {pipe_d[L-2:0], launch_data};
        end
    end

    assign I_valid = force_valid | pipe_v[L-1];
    assign I       = force_valid ? force_data : pipe_d[L-1];

    // Scoreboard pop: every accepted output word must match the oldest expected word.
    always @(negedge CLK) begin
        if (ASYNCRESETN && O_valid && O_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_word got=%0h exp=none", O);
            end else begin
                exp_word = exp_q.pop_front();
                if (O !== exp_word) begin
                    failures++;
                    $display("FAIL sb_word got=%0h exp=%0h", O, exp_word);
                end
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic drain;
        O_ready = 1'b1;
        for (int k = 0; k < 40 && count != 0; k++) tick();
        O_ready = 1'b0;
        checks++;
        if (count !== 4'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", count); end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL drain_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset;
        ASYNCRESETN = 1'b0;
        tick(); tick();
        ASYNCRESETN = 1'b1;
        tick(); tick();
        checks++;
        if (credit_ok !== 1'b1) begin failures++; $display("FAIL reset_credit got=%0b exp=1", credit_ok); end
        checks++;
        if (O_valid !== 1'b0) begin failures++; $display("FAIL reset_ovalid got=%0b exp=0", O_valid); end
        checks++;
        if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
`ifdef PIPE_CREDIT_FIFO_ERR_CHECK_EN
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
`endif
    endtask

    task automatic test_reset_midstream;
        O_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            launch = 1'b1;
            launch_data = W'(i);
            exp_q.push_back(W'(i));
            tick();
        end
        launch = 1'b0;
        tick(); tick();
        checks++;
        if (count !== 4'd5) begin failures++; $display("FAIL midreset_pre_count got=%0d exp=5", count); end
        ASYNCRESETN = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (count !== 4'd0) begin failures++; $display("FAIL midreset_count got=%0d exp=0", count); end
        checks++;
        if (O_valid !== 1'b0) begin failures++; $display("FAIL midreset_ovalid got=%0b exp=0", O_valid); end
        checks++;
        if (credit_ok !== 1'b1) begin failures++; $display("FAIL midreset_credit got=%0b exp=1", credit_ok); end
        tick();
        ASYNCRESETN = 1'b1;
        tick();
    endtask

    task automatic test_single_word;
        O_ready = 1'b1;
        launch = 1'b1;
        launch_data = 4'hA;
        exp_q.push_back(4'hA);
        for (int c = 1; c <= 6; c++) begin
            tick();
            launch = 1'b0;
            if (c == 4) begin
                checks++;
                if (O_valid !== 1'b0) begin failures++; $display("FAIL single_early_ovalid got=%0b exp=0", O_valid); end
                checks++;
                if (I_valid !== 1'b1) begin failures++; $display("FAIL single_ivalid got=%0b exp=1", I_valid); end
            end
            if (c == 5) begin
                checks++;
                if (O_valid !== 1'b1 || O !== 4'hA) begin
                    failures++; $display("FAIL single_out got=%0b/%0h exp=1/a", O_valid, O);
                end
                checks++;
                if (count !== 4'd1) begin failures++; $display("FAIL single_count1 got=%0d exp=1", count); end
            end
            if (c == 6) begin
                checks++;
                if (count !== 4'd0) begin failures++; $display("FAIL single_count0 got=%0d exp=0", count); end
            end
        end
        O_ready = 1'b0;
    endtask

    task automatic test_fill_drain;
        O_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            launch = (i < 8);
            launch_data = W'(i);
            checks++;
            if (credit_ok !== (i < 8)) begin
                failures++; $display("FAIL fill_credit cycle=%0d got=%0b exp=%0b", i, credit_ok, (i < 8));
            end
            if (i < 8) exp_q.push_back(W'(i));
            tick();
        end
        launch = 1'b0;
        repeat (6) tick();
        checks++;
        if (count !== 4'd8) begin failures++; $display("FAIL fill_count got=%0d exp=8", count); end
        checks++;
        if (O !== 4'h0 || credit_ok !== 1'b0) begin
            failures++; $display("FAIL fill_head_credit got=%0h/%0b exp=0/0", O, credit_ok);
        end
        O_ready = 1'b1;
        tick();
        checks++;
        if (credit_ok !== 1'b1 || count !== 4'd7) begin
            failures++; $display("FAIL drain_credit got=%0b/%0d exp=1/7", credit_ok, count);
        end
        drain();
    endtask

    task automatic test_steady;
        O_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            launch = 1'b1;
            launch_data = W'(i % 16);
            exp_q.push_back(W'(i % 16));
            checks++;
            if (credit_ok !== 1'b1) begin failures++; $display("FAIL steady_credit cycle=%0d got=%0b exp=1", i, credit_ok); end
            if (i >= 5) begin
                checks++;
                if (count !== 4'd1) begin failures++; $display("FAIL steady_count cycle=%0d got=%0d exp=1", i, count); end
            end
            tick();
        end
        launch = 1'b0;
        drain();
    endtask

    task automatic test_full_push_pop;
        O_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            launch = 1'b1;
            launch_data = W'(8 + i);
            exp_q.push_back(W'(8 + i));
            tick();
        end
        launch = 1'b0;
        repeat (6) tick();
        force_valid = 1'b1;
        force_data = 4'h5;
        O_ready = 1'b1;
        exp_q.push_back(4'h5);
        tick();
        force_valid = 1'b0;
        O_ready = 1'b0;
        checks++;
        if (count !== 4'd8) begin failures++; $display("FAIL fullpp_count got=%0d exp=8", count); end
        force_valid = 1'b1;
        force_data = 4'hF;
        tick();
        force_valid = 1'b0;
        checks++;
        if (count !== 4'd8) begin failures++; $display("FAIL drop_count got=%0d exp=8", count); end
`ifdef PIPE_CREDIT_FIFO_ERR_CHECK_EN
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL drop_err got=%0b exp=1", err); end
`endif
        drain();
        checks++;
        if (credit_ok !== 1'b1) begin failures++; $display("FAIL fullpp_credit got=%0b exp=1", credit_ok); end
    endtask

    task automatic test_credit_violation;
        ASYNCRESETN = 1'b0;
        tick();
        ASYNCRESETN = 1'b1;
        tick();
        O_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            launch = 1'b1;
            launch_data = W'(15 - i);
            exp_q.push_back(W'(15 - i));
            tick();
        end
        launch = 1'b0;
        repeat (6) tick();
`ifdef PIPE_CREDIT_FIFO_ERR_CHECK_EN
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL viol_err_pre got=%0b exp=0", err); end
`endif
        launch = 1'b1;
        launch_data = 4'h3;
        tick();
        launch = 1'b0;
`ifdef PIPE_CREDIT_FIFO_ERR_CHECK_EN
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL viol_err got=%0b exp=1", err); end
`endif
        O_ready = 1'b1;
        tick();
        O_ready = 1'b0;
        checks++;
        if (credit_ok !== 1'b1 || count !== 4'd7) begin
            failures++; $display("FAIL viol_inflight got=%0b/%0d exp=1/7", credit_ok, count);
        end
        repeat (3) tick();
`ifdef PIPE_CREDIT_FIFO_ERR_CHECK_EN
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL viol_err_sticky got=%0b exp=1", err); end
`endif
        drain();
        ASYNCRESETN = 1'b0;
        #1;
`ifdef PIPE_CREDIT_FIFO_ERR_CHECK_EN
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL viol_err_clear got=%0b exp=0", err); end
`endif
        tick();
        ASYNCRESETN = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_reset_midstream();
        test_fill_drain();
        test_single_word();
        test_steady();
        test_full_push_pop();
        test_credit_violation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
